// File: rtl/zcmt_jt_responder.sv
// ZCMT jump-table fetch responder: one outstanding table-word read at a time.
// Defining ZCMT_JT_CACHE_EN adds a direct-mapped entry cache; otherwise every aligned read goes to memory.
module zcmt_jt_responder #(
    parameter  int unsigned INDEX_WIDTH = 10,
    parameter  int unsigned TAG_WIDTH   = 24,
    parameter  int unsigned ID_WIDTH    = 1,
    parameter  int unsigned ENTRIES     = 8,
    localparam int unsigned ADDR_WIDTH  = INDEX_WIDTH + TAG_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [INDEX_WIDTH-1:0] addr_index_i,
    input  logic [TAG_WIDTH-1:0]   addr_tag_i,
    input  logic                   tag_valid_i,
    input  logic                   kill_req_i,
    input  logic [ID_WIDTH-1:0]    id_i,
    output logic                   rvalid_o,
    output logic [ID_WIDTH-1:0]    rid_o,
    output logic [31:0]            rdata_o,
    output logic                   rerr_o,
    output logic                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_err_i
);

    localparam int unsigned WADDR_WIDTH = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        MISS_REQ,
        MISS_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rerr_q, rerr_d;
    logic                   killed_q, killed_d;

    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   accept;
    logic                   misaligned;
    logic                   hit;
    logic [31:0]            hit_data;
    logic                   fill;

    assign req_addr   = {addr_tag_i, addr_index_i};
    assign gnt_o      = (state_q == IDLE) & tag_valid_i;
    assign accept     = req_i & gnt_o;
    assign misaligned = |req_addr[1:0];

    // A kill during the response cycle swallows the pulse; payload is zero whenever no pulse is driven.
    assign rvalid_o   = (state_q == RESP) & ~kill_req_i;
    assign rid_o      = rvalid_o ? id_q    : '0;
    assign rdata_o    = rvalid_o ? rdata_q : '0;
    assign rerr_o     = rvalid_o & rerr_q;
    assign mem_req_o  = (state_q == MISS_REQ);
    assign mem_addr_o = mem_req_o ? {waddr_q, 2'b00} : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        waddr_d  = waddr_q;
        id_d     = id_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        killed_d = killed_q;
        fill     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    waddr_d  = req_addr[ADDR_WIDTH-1:2];
                    id_d     = id_i;
                    killed_d = 1'b0;
                    if (misaligned) begin
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        state_d = RESP;
                    end else if (hit) begin
                        rdata_d = hit_data;
                        rerr_d  = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            MISS_REQ: begin
                // Once granted the read must complete, so a same-cycle kill only marks it.
                if (mem_gnt_i) begin
                    killed_d = kill_req_i;
                    state_d  = MISS_WAIT;
                end else if (kill_req_i) begin
                    state_d = IDLE;
                end
            end
            MISS_WAIT: begin
                if (kill_req_i) begin
                    killed_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    fill    = ~mem_err_i;
                    rdata_d = mem_rdata_i;
                    rerr_d  = mem_err_i;
                    state_d = (killed_q | kill_req_i) ? IDLE : RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_i) begin
            state_q  <= IDLE;
            waddr_q  <= '0;
            id_q     <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            id_q     <= id_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            killed_q <= killed_d;
        end
    end

`ifdef ZCMT_JT_CACHE_EN
    localparam int unsigned SET_BITS   = $clog2(ENTRIES);
    localparam int unsigned CTAG_WIDTH = WADDR_WIDTH - SET_BITS;

    logic [ENTRIES-1:0]    valid_q;
    logic [CTAG_WIDTH-1:0] tag_q  [ENTRIES];
    logic [31:0]           data_q [ENTRIES];
    logic                  no_fill_q;
    logic                  do_fill;

    logic [SET_BITS-1:0]   req_set, fill_set;
    logic [CTAG_WIDTH-1:0] req_ctag, fill_ctag;

    assign req_set   = req_addr[SET_BITS+1:2];
    assign req_ctag  = req_addr[ADDR_WIDTH-1:SET_BITS+2];
    assign fill_set  = waddr_q[SET_BITS-1:0];
    assign fill_ctag = waddr_q[WADDR_WIDTH-1:SET_BITS];

    // A flush in the accept cycle must not let a soon-to-be-invalid entry answer.
    assign hit      = valid_q[req_set] & (tag_q[req_set] == req_ctag) & ~flush_i;
    assign hit_data = data_q[req_set];
    assign do_fill  = fill & ~no_fill_q & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            no_fill_q <= 1'b0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else if (do_fill) begin
                valid_q[fill_set] <= 1'b1;
            end
            if (state_q == IDLE) begin
                no_fill_q <= 1'b0;
            end else if (flush_i && (state_q == MISS_REQ || state_q == MISS_WAIT)) begin
                no_fill_q <= 1'b1;
            end
        end
    end

    // NOTE: entry tags and data are not reset; valid_q alone decides whether they mean anything.
    always_ff @(posedge clk_i) begin
        if (do_fill) begin
            tag_q[fill_set]  <= fill_ctag;
            data_q[fill_set] <= mem_rdata_i;
        end
    end
`else
    localparam int unsigned unused_entries = ENTRIES;
    logic                   unused_cache_sigs;

    assign hit               = 1'b0;
    assign hit_data          = '0;
    assign unused_cache_sigs = flush_i | fill;
`endif

endmodule

// File: tb/tb_zcmt_jt_responder.sv
// Self-checking bench for zcmt_jt_responder: directed scenarios plus randomized reads,
// checked against a word-address cache model that follows ZCMT_JT_CACHE_EN.
module tb_zcmt_jt_responder;

    localparam int ENTRIES  = 8;
    localparam int SET_BITS = 3;
`ifdef ZCMT_JT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req = 1'b0;
    logic        gnt_o;
    logic [9:0]  addr_index = '0;
    logic [23:0] addr_tag = '0;
    logic        tag_valid = 1'b0;
    logic        kill = 1'b0;
    logic [0:0]  id = '0;
    logic        rvalid_o;
    logic [0:0]  rid_o;
    logic [31:0] rdata_o;
    logic        rerr_o;
    logic        mem_req_o;
    logic [33:0] mem_addr_o;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model: which word address each set holds, and its data.
    bit          m_valid [ENTRIES];
    logic [31:0] m_waddr [ENTRIES];
    logic [31:0] m_data  [ENTRIES];

    zcmt_jt_responder #(
        .INDEX_WIDTH(10),
        .TAG_WIDTH  (24),
        .ID_WIDTH   (1),
        .ENTRIES    (ENTRIES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .addr_index_i(addr_index),
        .addr_tag_i  (addr_tag),
        .tag_valid_i (tag_valid),
        .kill_req_i  (kill),
        .id_i        (id),
        .rvalid_o    (rvalid_o),
        .rid_o       (rid_o),
        .rdata_o     (rdata_o),
        .rerr_o      (rerr_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
        .mem_err_i   (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_flush();
        if (CACHE) model_reset();
    endfunction

    function automatic bit model_hit(input logic [33:0] a);
        int s;
        s = int'(a[2 +: SET_BITS]);
        return CACHE && (a[1:0] == 2'b00) && m_valid[s] && (m_waddr[s] == a[33:2]);
    endfunction

    // One read transaction: drives the request, plays the memory, checks every observable step.
    // kill_ph: 0 none, 1 in MISS_REQ before grant, 2 in MISS_WAIT, 3 in the response cycle.
    // flush_ph: 0 none, 1 in the accept cycle, 2 in MISS_WAIT.
    task automatic do_read(input logic [33:0] a, input logic rid_in, input logic [31:0] mdata,
                           input logic merr, input int gd, input int rd,
                           input int kill_ph, input int flush_ph, input string nm);
        logic        mis;
        logic        exp_hit;
        logic        exp_rv;
        logic [31:0] exp_data;
        logic [33:0] exp_maddr;
        int          s;
        mis       = (a[1:0] != 2'b00);
        s         = int'(a[2 +: SET_BITS]);
        exp_hit   = model_hit(a) && (flush_ph != 1);
        exp_data  = mis ? 32'h0 : m_data[s];
        exp_maddr = {a[33:2], 2'b00};

        @(negedge clk);
        addr_tag   = a[33:10];
        addr_index = a[9:0];
        id         = rid_in;
        req        = 1'b1;
        tag_valid  = 1'b1;
        flush      = (flush_ph == 1);
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL %s gnt_idle: got %b exp 1", nm, gnt_o);
        end
        @(negedge clk);
        req   = 1'b0;
        flush = 1'b0;
        if (flush_ph == 1) model_flush();

        if (mis || exp_hit) begin
            kill   = (kill_ph == 3);
            exp_rv = (kill_ph != 3);
            #1;
            checks++;
            if (rvalid_o !== exp_rv || mem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL %s fast_resp: rvalid=%b mem_req=%b exp rvalid=%b mem_req=0",
                         nm, rvalid_o, mem_req_o, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rdata_o !== exp_data || rerr_o !== mis || rid_o !== rid_in) begin
                    failures++;
                    $display("FAIL %s fast_data: got %h/%b/%b exp %h/%b/%b",
                             nm, rdata_o, rerr_o, rid_o, exp_data, mis, rid_in);
                end
            end
        end else begin
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== exp_maddr || rvalid_o !== 1'b0 || gnt_o !== 1'b0) begin
                failures++;
                $display("FAIL %s miss_req: mem_req=%b addr=%h rvalid=%b gnt=%b exp 1/%h/0/0",
                         nm, mem_req_o, mem_addr_o, rvalid_o, gnt_o, exp_maddr);
            end
            if (kill_ph == 1) begin
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
                #1;
                checks++;
                if (mem_req_o !== 1'b0 || gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s kill_miss_req: mem_req=%b gnt=%b rvalid=%b exp 0/1/0",
                             nm, mem_req_o, gnt_o, rvalid_o);
                end
                return;
            end
            for (int k = 0; k < gd; k++) begin
                @(negedge clk);
                #1;
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== exp_maddr) begin
                    failures++;
                    $display("FAIL %s mem_hold: mem_req=%b addr=%h exp 1/%h", nm, mem_req_o, mem_addr_o, exp_maddr);
                end
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            kill    = (kill_ph == 2);
            flush   = (flush_ph == 2);
            #1;
            checks++;
            if (mem_req_o !== 1'b0 || gnt_o !== 1'b0) begin
                failures++;
                $display("FAIL %s mem_wait: mem_req=%b gnt=%b exp 0/0", nm, mem_req_o, gnt_o);
            end
            for (int k = 0; k < rd; k++) begin
                @(negedge clk);
                kill  = 1'b0;
                flush = 1'b0;
                #1;
                checks++;
                if (rvalid_o !== 1'b0 || gnt_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s wait_quiet: rvalid=%b gnt=%b exp 0/0", nm, rvalid_o, gnt_o);
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = mdata;
            mem_err    = merr;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mem_err    = 1'b0;
            kill       = 1'b0;
            flush      = 1'b0;
            if (flush_ph == 2) begin
                model_flush();
            end else if (CACHE && !merr) begin
                m_valid[s] = 1'b1;
                m_waddr[s] = a[33:2];
                m_data[s]  = mdata;
            end
            if (kill_ph == 2) begin
                #1;
                checks++;
                if (rvalid_o !== 1'b0 || gnt_o !== 1'b1) begin
                    failures++;
                    $display("FAIL %s kill_wait: rvalid=%b gnt=%b exp 0/1", nm, rvalid_o, gnt_o);
                end
                return;
            end
            kill   = (kill_ph == 3);
            exp_rv = (kill_ph != 3);
            #1;
            checks++;
            if (rvalid_o !== exp_rv || gnt_o !== 1'b0) begin
                failures++;
                $display("FAIL %s miss_resp: rvalid=%b gnt=%b exp %b/0", nm, rvalid_o, gnt_o, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rdata_o !== mdata || rerr_o !== merr || rid_o !== rid_in) begin
                    failures++;
                    $display("FAIL %s miss_data: got %h/%b/%b exp %h/%b/%b",
                             nm, rdata_o, rerr_o, rid_o, mdata, merr, rid_in);
                end
            end
        end
        @(negedge clk);
        kill = 1'b0;
        #1;
        checks++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL %s back_idle: gnt=%b rvalid=%b exp 1/0", nm, gnt_o, rvalid_o);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        tag_valid = 1'b0;
        req       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h0 || rerr_o !== 1'b0 ||
            rid_o !== 1'b0 || mem_addr_o !== 34'h0 || gnt_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rvalid=%b mem_req=%b rdata=%h rerr=%b rid=%b maddr=%h gnt=%b exp all 0",
                     rvalid_o, mem_req_o, rdata_o, rerr_o, rid_o, mem_addr_o, gnt_o);
        end
        tag_valid = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_gnt: got %b exp 1", gnt_o);
        end
        model_reset();
        @(negedge clk);
        rst        = 1'b0;
        req        = 1'b1;
        tag_valid  = 1'b0;
        addr_tag   = 24'h4;
        addr_index = 10'h004;
        #1;
        checks++;
        if (gnt_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_gnt: got %b exp 0", gnt_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_accept: mem_req=%b rvalid=%b exp 0/0", mem_req_o, rvalid_o);
        end
        req       = 1'b0;
        tag_valid = 1'b1;
    endtask

    task automatic test_miss_then_hit();
        do_read(34'h1004, 1'b1, 32'h8000_0120, 1'b0, 1, 2, 0, 0, "miss_first");
        do_read(34'h1004, 1'b0, 32'hDEAD_0001, 1'b0, 0, 0, 0, 0, "hit_repeat");
    endtask

    task automatic test_conflict();
        do_read(34'h1004, 1'b0, 32'h1111_1004, 1'b0, 0, 1, 0, 0, "conflict_a");
        do_read(34'h1024, 1'b1, 32'h2222_1024, 1'b0, 2, 0, 0, 0, "conflict_b");
        do_read(34'h1004, 1'b0, 32'h3333_1004, 1'b0, 0, 0, 0, 0, "conflict_a_again");
        do_read(34'h1024, 1'b1, 32'h4444_1024, 1'b0, 1, 1, 0, 0, "conflict_b_again");
    endtask

    task automatic test_misaligned();
        do_read(34'h1006, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0, "misaligned_2");
        do_read(34'h1025, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0, "misaligned_1");
    endtask

    task automatic test_kill();
        do_read(34'h2000, 1'b1, 32'h0000_0055, 1'b0, 1, 2, 2, 0, "kill_wait");
        do_read(34'h2000, 1'b0, 32'hBAD0_0000, 1'b0, 0, 0, 0, 0, "kill_reread");
        do_read(34'h2104, 1'b1, 32'hBAD0_0001, 1'b0, 2, 0, 1, 0, "kill_mem_req");
        do_read(34'h2000, 1'b1, 32'hBAD0_0002, 1'b0, 0, 0, 3, 0, "kill_resp_hit");
        do_read(34'h2208, 1'b0, 32'h0000_2208, 1'b0, 0, 1, 3, 0, "kill_resp_miss");
        do_read(34'h2208, 1'b1, 32'hBAD0_0003, 1'b0, 0, 0, 0, 0, "kill_resp_reread");
    endtask

    task automatic test_flush();
        do_read(34'h3000, 1'b0, 32'h0000_00AA, 1'b0, 0, 2, 0, 2, "flush_wait");
        do_read(34'h3000, 1'b1, 32'h0000_00AB, 1'b0, 0, 0, 0, 0, "flush_reread");
        do_read(34'h3000, 1'b0, 32'h0000_00AC, 1'b0, 1, 0, 0, 1, "flush_accept");
        do_read(34'h3000, 1'b1, 32'hBAD0_0004, 1'b0, 0, 0, 0, 0, "flush_accept_reread");
    endtask

    task automatic test_error();
        do_read(34'h4000, 1'b1, 32'h1234_4000, 1'b1, 0, 1, 0, 0, "err_resp");
        do_read(34'h4000, 1'b0, 32'h5678_4000, 1'b0, 0, 0, 0, 0, "err_reread");
    endtask

    task automatic test_reset_mid();
        do_read(34'h5000, 1'b0, 32'h0000_5000, 1'b0, 0, 0, 0, 0, "rst_prefill");
        @(negedge clk);
        addr_tag   = 24'h18;
        addr_index = 10'h000;
        req        = 1'b1;
        @(negedge clk);
        req = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_miss: mem_req=%b exp 1", mem_req_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state: mem_req=%b gnt=%b rvalid=%b exp 0/1/0", mem_req_o, gnt_o, rvalid_o);
        end
        do_read(34'h5000, 1'b1, 32'h0001_5000, 1'b0, 0, 0, 0, 0, "rst_reread");
    endtask

    task automatic test_back_to_back();
        int          n_rv;
        int          n_mreq;
        int          exp_rv;
        int          exp_mreq;
        logic [31:0] exp_data;
        do_read(34'h1100, 1'b1, 32'h1234_5678, 1'b0, 0, 0, 0, 0, "b2b_fill");
        exp_rv   = model_hit(34'h1100) ? 2 : 0;
        exp_mreq = model_hit(34'h1100) ? 0 : 4;
        exp_data = m_data[int'(6'h00)];
        n_rv     = 0;
        n_mreq   = 0;
        @(negedge clk);
        addr_tag   = 24'h4;
        addr_index = 10'h100;
        id         = 1'b1;
        req        = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (rvalid_o === 1'b1) begin
                n_rv++;
                checks++;
                if (rdata_o !== exp_data) begin
                    failures++;
                    $display("FAIL b2b_data: got %h exp %h", rdata_o, exp_data);
                end
            end
            if (mem_req_o === 1'b1) n_mreq++;
        end
        req = 1'b0;
        checks++;
        if (n_rv != exp_rv || n_mreq != exp_mreq) begin
            failures++;
            $display("FAIL b2b_rate: rvalid pulses=%0d mem_req cycles=%0d exp %0d/%0d", n_rv, n_mreq, exp_rv, exp_mreq);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [33:0] a;
        int          kp;
        int          fp;
        for (int i = 0; i < 60; i++) begin
            a = 34'h7000 + 34'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            kp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            fp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_read(a, 1'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), kp, fp, "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_misaligned();
        test_kill();
        test_flush();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zcmt_jt_responder.md
Name: zcmt_jt_responder

Overview:
- Data-side responder for ZCMT jump-table fetches issued by the cm.jt/cm.jalt decode path.
- Accepts single-word dcache-style read requests (index, tag, valid/grant, rvalid) and returns the 32-bit table entry.
- Holds a small direct-mapped cache of table entries; misses go to a simple memory read port.
- Sits between the ZCMT decoder's request port and the data memory/cache arbiter in CV32A60x-class cores.

Parameters:
- INDEX_WIDTH, 10, width of the request address index.
- TAG_WIDTH, 24, width of the request address tag; full address is {tag, index}, ADDR_WIDTH = INDEX_WIDTH + TAG_WIDTH.
- ID_WIDTH, 1, width of the request/response transaction ID.
- ENTRIES, 8, number of cached table words; must be a power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  invalidate all cached entries (JVT CSR write, fence.i).
- req_i  in  1  request valid.
- gnt_o  out  1  request grant.
- addr_index_i  in  INDEX_WIDTH  address index.
- addr_tag_i  in  TAG_WIDTH  address tag.
- tag_valid_i  in  1  tag valid; must be high together with req_i.
- kill_req_i  in  1  kill the outstanding request.
- id_i  in  ID_WIDTH  request ID.
- rvalid_o  out  1  response valid, one-cycle pulse.
- rid_o  out  ID_WIDTH  response ID.
- rdata_o  out  32  table entry.
- rerr_o  out  1  response error: misaligned address or memory error.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  ADDR_WIDTH  memory word address, bits [1:0] = 0.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory data valid.
- mem_rdata_i  in  32  memory data.
- mem_err_i  in  1  memory error, sampled with mem_rvalid_i.

Behaviour:
- Reset (rst_i high at clk_i edge):
  - state IDLE; all entry valid bits cleared.
  - All outputs 0 except gnt_o, which is combinationally 1 in IDLE.
- States: IDLE, RESP, MISS_REQ, MISS_WAIT.
- Request acceptance:
  - gnt_o = (state == IDLE) & tag_valid_i.
  - A request is accepted on req_i & gnt_o; ID and address are captured.
  - req_i high with tag_valid_i low: no grant, stall.
- Address and indexing:
  - Set index = addr[log2(ENTRIES)+1:2]; the stored tag is the remaining upper address bits.
- Misaligned request (addr[1:0] != 0):
  - IDLE -> RESP with rerr_o = 1, rdata_o = 0.
  - No lookup, no memory access.
- Hit (valid and tag match, flush_i low in the accept cycle):
  - IDLE -> RESP.
  - rvalid_o is asserted the cycle after the grant, with the cached data, rerr_o = 0.
- Miss:
  - IDLE -> MISS_REQ.
  - mem_req_o and mem_addr_o are held stable until mem_gnt_i; then -> MISS_WAIT.
  - On mem_rvalid_i:
    - fill the entry unless mem_err_i is set or a flush occurred during the miss;
    - drive rvalid_o next cycle (RESP) with mem_rdata_i, and rerr_o = mem_err_i.
- RESP lasts one cycle, then -> IDLE. Back-to-back hits sustain 1 request per 2 cycles.
- kill_req_i:
  - Sampled in RESP, MISS_REQ and MISS_WAIT.
  - In RESP: suppress rvalid_o.
  - In MISS_REQ before grant: drop mem_req_o, return to IDLE.
  - After mem grant: stay in MISS_WAIT until mem_rvalid_i; the fill still occurs; no rvalid_o is issued.
- flush_i:
  - Clears all valid bits the next cycle.
  - Asserted in the same cycle as an accepted request: forces a miss.
  - Asserted while in MISS_REQ/MISS_WAIT: sets a no-fill flag; the response is still returned.
- Exactly one outstanding memory transaction. gnt_o stays low until it completes.
- Reset mid-transaction returns to IDLE immediately. The memory side shares rst_i, so no stale mem_rvalid_i arrives.

Optional Feature:
- Macro: ZCMT_JT_CACHE_EN.
- Defined: caching behaves as described above.
- Undefined:
  - No entry storage; every aligned request takes the miss path (pure bridge).
  - flush_i is ignored.
  - Misaligned, kill and error handling are unchanged.

Test Plan:
- Miss then hit: read 0x0000_1004 -> mem_addr_o = 0x1004; mem_rdata_i = 0x8000_0120 -> rvalid_o with 0x8000_0120. Repeat the read -> rvalid_o the cycle after grant, no mem_req_o.
- Conflict: read 0x1004, then 0x1024 (same set, ENTRIES = 8) -> both miss; re-read 0x1004 -> miss again, mem_addr_o = 0x1004.
- Misaligned: read 0x1006 -> rvalid_o with rerr_o = 1, rdata_o = 0; mem_req_o never asserted.
- Kill: read 0x2000 (miss); kill_req_i in MISS_WAIT; mem_rdata_i = 0x55 -> no rvalid_o, gnt_o returns 1 cycle after mem_rvalid_i; re-read 0x2000 -> hit with 0x55.
- Flush during miss: read 0x3000, flush_i in MISS_WAIT -> response 0xAA delivered; re-read 0x3000 -> miss.
- Error and reset:
  - mem_err_i = 1 -> rerr_o = 1 and no fill.
  - rst_i asserted in MISS_REQ -> next cycle mem_req_o = 0, gnt_o = 1, and the next read of a prior hit address misses.
